// File: rtl/fifo_rd_stream_ctrl.sv
// Read-side controller for the two-bank FIFO: occupancy tracking, credit-based deq issue,
// read-latency skid buffer and valid/ready output. Optional statistics: FIFO_RDSTR_STAT_EN.
module fifo_rd_stream_ctrl #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH     = 4608,
  parameter int unsigned CNT_W     = 13,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             inc,
  output logic             fifo_deq,
  output logic             fifo_rrst,
  input  logic [DW-1:0]    fifo_dot,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             full,
  output logic             ovf,
  output logic [CNT_W-1:0] occ
`ifdef FIFO_RDSTR_STAT_EN
  ,
  output logic [31:0]      stat_words,
  output logic [31:0]      stat_stall
`endif
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned BW = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [BW-1:0]    BUF_FULL = BW'(BUF_DEPTH);

  logic [CNT_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d;
  logic              rrst_q;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [DW-1:0]     mem_q [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]     cnt_q, cnt_d;

  logic        clr, push, pop, inc_acc;
  int unsigned inflight;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign clr = RST | flush;

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 32'(pipe_q[i]);
    end

    full       = (occ_q == DEPTH_C);
    // Credits cover words in flight plus words already buffered, so a push never overruns.
    fifo_deq   = (occ_q != '0) && ((inflight + 32'(cnt_q)) < BUF_DEPTH) && !rrst_q;
    dout_valid = (cnt_q != '0);
    dout       = mem_q[rd_ptr_q];
    push       = pipe_q[RD_LAT-1];
    pop        = dout_valid & dout_ready;
    inc_acc    = inc & ~(full & ~fifo_deq);

    occ_d = occ_q;
    unique case ({inc_acc, fifo_deq})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    ovf_d = ovf_q | (inc & full & ~fifo_deq);

    pipe_d    = pipe_q << 1;
    pipe_d[0] = fifo_deq;

    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + BW'(1);
      2'b01:   cnt_d = cnt_q - BW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    rrst_q <= clr;
    if (clr) begin
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= fifo_dot;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!clr) begin
      assert (!(push && !pop && (cnt_q == BUF_FULL)));
    end
  end

  assign fifo_rrst = rrst_q;
  assign ovf       = ovf_q;
  assign occ       = occ_q;

`ifdef FIFO_RDSTR_STAT_EN
  logic [31:0] words_q, stall_q;

  always_ff @(posedge CLK) begin
    if (clr) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && (words_q != '1)) begin
        words_q <= words_q + 32'd1;
      end
      if (dout_valid && !dout_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule
